xadc_measurement_selector: RTL and testbench

Registered, parametrised successor to the combinational XADC data mux. It selects one of `NUM_SRC` measurement streams (raw, averaged, scaled, or additional channels) and forwards that stream's samples to the display/processing path. On every source change it blanks the output for a fixed time, then resynchronises to the new stream's sample strobe, so no mixed or stale value is ever presented as valid. A hold input freezes the displayed value.

---
 rtl/xadc_measurement_selector.sv | 153 +++++++++++++++
 tb/tb_xadc_measurement_selector.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_measurement_selector.sv
// xadc_measurement_selector
// Registered source selector for XADC measurement streams. Picks one of
// NUM_SRC sample streams, blanks the output after every source change, then
// resynchronises to the new stream's strobe before forwarding samples.
// Optional auto-scan (dwell a fixed number of samples per source, then
// advance) is compiled in when XADC_SEL_AUTOSCAN_EN is defined.
module xadc_measurement_selector #(
  parameter int NUM_SRC       = 4,
  parameter int DATA_W        = 16,
  parameter int BLANK_CYCLES  = 4,
  parameter int DWELL_SAMPLES = 8,
  localparam int SEL_W        = $clog2(NUM_SRC + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  input  logic                      scan_en,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [DATA_W-1:0]         meas_data,
  output logic                      meas_valid,
  output logic [SEL_W-1:0]          active_src,
  output logic                      switching
);

  localparam int CNT_W   = $clog2(BLANK_CYCLES + 1);
  localparam int DWELL_W = $clog2(DWELL_SAMPLES + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_WAIT,
    ST_TRACK
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    blank_cnt;
  logic [SEL_W-1:0]    sel_eff;
  logic                scanning;
  logic                cur_vld_p0;
  logic [DATA_W-1:0]   cur_data_p0;

  // Out-of-range selections behave exactly like OFF.
  assign sel_eff = (32'(sel) > 32'(NUM_SRC)) ? '0 : sel;

`ifdef XADC_SEL_AUTOSCAN_EN
  logic [DWELL_W-1:0] dwell_cnt;
  logic [SEL_W-1:0]   next_src;
  logic               advance;

  assign scanning = scan_en && (active_src != '0);
  assign next_src = (active_src == SEL_W'(NUM_SRC)) ? SEL_W'(1)
                                                    : active_src + SEL_W'(1);
  // Advancing is paused by hold so a frozen display is not blanked under it.
  assign advance  = scanning && (state == ST_TRACK) && !hold &&
                    (dwell_cnt == DWELL_W'(DWELL_SAMPLES));
`else
  logic               unused_scan;
  logic [DWELL_W-1:0] unused_dwell;

  assign scanning     = 1'b0;
  assign unused_scan  = scan_en;
  assign unused_dwell = '0;
`endif

  // Strobe and data of the stream that currently owns the output.
  always_comb begin
    cur_vld_p0  = 1'b0;
    cur_data_p0 = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (32'(active_src) == 32'(i + 1)) begin
        cur_vld_p0  = src_valid[i];
        cur_data_p0 = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Selector FSM: change detection first (it wins over a same-cycle strobe),
  // then per-state blanking, resynchronisation and tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_OFF;
      active_src <= '0;
      meas_data  <= '0;
      meas_valid <= 1'b0;
      switching  <= 1'b0;
      blank_cnt  <= '0;
`ifdef XADC_SEL_AUTOSCAN_EN
      dwell_cnt  <= '0;
`endif
    end else begin
      meas_valid <= 1'b0;
      if ((sel_eff == '0) && (active_src != '0)) begin
        state      <= ST_OFF;
        active_src <= '0;
        meas_data  <= '0;
        switching  <= 1'b0;
        blank_cnt  <= '0;
`ifdef XADC_SEL_AUTOSCAN_EN
        dwell_cnt  <= '0;
`endif
      end else if (!scanning && (sel_eff != active_src)) begin
        state      <= ST_BLANK;
        active_src <= sel_eff;
        meas_data  <= '0;
        switching  <= 1'b1;
        blank_cnt  <= BLANK_LOAD;
`ifdef XADC_SEL_AUTOSCAN_EN
        dwell_cnt  <= '0;
      end else if (advance) begin
        state      <= ST_BLANK;
        active_src <= next_src;
        meas_data  <= '0;
        switching  <= 1'b1;
        blank_cnt  <= BLANK_LOAD;
        dwell_cnt  <= '0;
`endif
      end else begin
        case (state)
          ST_BLANK: begin
            blank_cnt <= blank_cnt - CNT_W'(1);
            if (blank_cnt == CNT_W'(1)) state <= ST_WAIT;
          end
          ST_WAIT: begin
            // First sample after blanking is taken even under hold.
            if (cur_vld_p0) begin
              meas_data  <= cur_data_p0;
              meas_valid <= 1'b1;
              switching  <= 1'b0;
              state      <= ST_TRACK;
`ifdef XADC_SEL_AUTOSCAN_EN
              if (scanning) dwell_cnt <= dwell_cnt + DWELL_W'(1);
`endif
            end
          end
          ST_TRACK: begin
            if (cur_vld_p0 && !hold) begin
              meas_data  <= cur_data_p0;
              meas_valid <= 1'b1;
`ifdef XADC_SEL_AUTOSCAN_EN
              if (scanning) dwell_cnt <= dwell_cnt + DWELL_W'(1);
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xadc_measurement_selector.sv
// Bench for xadc_measurement_selector: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural model.
module tb_xadc_measurement_selector;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int B  = 4;
  localparam int D  = 2;
  localparam int SW = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [SW-1:0]     sel = '0;
  logic              hold = 1'b0;
  logic              scan_en = 1'b0;
  logic [N*W-1:0]    src_data = '0;
  logic [N-1:0]      src_valid = '0;
  logic [W-1:0]      meas_data;
  logic              meas_valid;
  logic [SW-1:0]     active_src;
  logic              switching;

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner of the output, blanking cycles still to run,
  // whether the new stream has delivered its first sample, dwell count.
  int          m_owner, m_blank, m_cnt;
  bit          m_locked, m_valid;
  logic [W-1:0] m_data;
  logic [W-1:0] lane [N];

  xadc_measurement_selector #(
    .NUM_SRC(N), .DATA_W(W), .BLANK_CYCLES(B), .DWELL_SAMPLES(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .hold(hold), .scan_en(scan_en),
    .src_data(src_data), .src_valid(src_valid), .meas_data(meas_data),
    .meas_valid(meas_valid), .active_src(active_src), .switching(switching)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".meas_data"},  32'(meas_data),  32'(m_data));
    chk({tag, ".meas_valid"}, 32'(meas_valid), 32'(m_valid));
    chk({tag, ".active_src"}, 32'(active_src), 32'(m_owner));
    chk({tag, ".switching"},  32'(switching),  32'((m_owner != 0) && !m_locked));
  endtask

  task automatic model_reset();
    m_owner = 0; m_blank = 0; m_cnt = 0; m_locked = 0; m_valid = 0; m_data = '0;
  endtask

  task automatic model_step();
    int es;
    bit scan;
    es = (int'(sel) > N) ? 0 : int'(sel);
`ifdef XADC_SEL_AUTOSCAN_EN
    scan = scan_en && (m_owner != 0);
`else
    scan = 1'b0;
`endif
    m_valid = 0;
    if (es == 0 && m_owner != 0) begin
      m_owner = 0; m_data = '0; m_locked = 0; m_blank = 0; m_cnt = 0;
    end else if (!scan && es != m_owner) begin
      m_owner = es; m_data = '0; m_locked = 0; m_blank = B; m_cnt = 0;
    end else if (scan && m_locked && m_cnt == D && !hold) begin
      m_owner = (m_owner % N) + 1; m_data = '0; m_locked = 0; m_blank = B; m_cnt = 0;
    end else if (m_owner != 0) begin
      if (m_blank > 0) m_blank--;
      else if (src_valid[m_owner-1] && (!m_locked || !hold)) begin
        m_data = lane[m_owner-1]; m_valid = 1; m_locked = 1;
        if (scan) m_cnt++;
      end
    end
  endtask

  task automatic cyc();
    for (int i = 0; i < N; i++) src_data[i*W +: W] = lane[i];
    model_step();
    @(posedge clk); #1;
    check_all("cyc");
  endtask

  int seq [$];
  int exp_seq [5] = '{1, 2, 3, 4, 1};

  initial begin
    for (int i = 0; i < N; i++) lane[i] = '0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;

    // OFF with every stream strobing: nothing is forwarded.
    sel = 0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) lane[i] = W'($urandom);
      src_valid = '1;
      cyc();
    end

    // OFF -> source 2, stream 1 strobing every 3 cycles.
    lane[1] = 16'h0ABC;
    sel = 2;
    for (int c = 0; c < 20; c++) begin
      src_valid = (c % 3 == 2) ? 4'b0010 : 4'b0000;
      cyc();
      if (c == 0) begin
        chk("sel_chg_switching", 32'(switching), 32'd1);
        chk("sel_chg_active", 32'(active_src), 32'd2);
        chk("sel_chg_data", 32'(meas_data), 32'd0);
      end
    end
    chk("first_capture", 32'(meas_data), 32'h0ABC);

    // Track source 3, then hold while its data changes.
    lane[2] = 16'h5555;
    sel = 3;
    for (int c = 0; c < 14; c++) begin
      src_valid = (c % 2 == 0) ? 4'b0100 : 4'b0000;
      cyc();
    end
    hold = 1'b1;
    lane[2] = 16'h1234;
    for (int c = 0; c < 6; c++) begin
      src_valid = (c % 2 == 0) ? 4'b0100 : 4'b0000;
      cyc();
    end
    chk("hold_frozen", 32'(meas_data), 32'h5555);
    hold = 1'b0;
    src_valid = 4'b0100;
    cyc();
    chk("hold_release_data", 32'(meas_data), 32'h1234);
    chk("hold_release_valid", 32'(meas_valid), 32'd1);

    // Track source 2, then change to 3 on a stream-1 strobe, then to 1 mid-blank.
    sel = 2;
    for (int c = 0; c < 8; c++) begin
      lane[1] = W'($urandom);
      src_valid = 4'b0010;
      cyc();
    end
    sel = 3;
    src_valid = 4'b0010;
    cyc();
    chk("chg_prio_valid", 32'(meas_valid), 32'd0);
    chk("chg_prio_data", 32'(meas_data), 32'd0);
    src_valid = 4'b1111;
    cyc();
    cyc();
    sel = 1;
    cyc();
    chk("reblank_active", 32'(active_src), 32'd1);
    chk("reblank_switching", 32'(switching), 32'd1);
    for (int c = 0; c < 8; c++) begin
      lane[0] = W'($urandom);
      src_valid = 4'b0001;
      cyc();
    end

    // Out-of-range selection is OFF.
    sel = 5;
    src_valid = '1;
    cyc();
    chk("sel5_active", 32'(active_src), 32'd0);
    chk("sel5_data", 32'(meas_data), 32'd0);
    for (int c = 0; c < 4; c++) cyc();

    // Asynchronous reset while tracking.
    sel = 1;
    for (int c = 0; c < 20 && !(m_locked && m_data != 0); c++) begin
      lane[0] = W'($urandom_range(1, 65535));
      src_valid = 4'b0001;
      cyc();
    end
    chk("pre_reset_tracking", 32'(switching), 32'd0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk); #1;
    check_all("reset_held");
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) cyc();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) sel = SW'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0);
      scan_en = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < N; i++) begin
        src_valid[i] = ($urandom_range(0, 2) == 0);
        if (src_valid[i]) lane[i] = W'($urandom);
      end
      cyc();
    end
    hold = 1'b0;
    scan_en = 1'b0;

`ifdef XADC_SEL_AUTOSCAN_EN
    // Auto-scan from source 1 with every stream strobing.
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    sel = 1;
    scan_en = 1'b1;
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < N; i++) lane[i] = W'($urandom);
      src_valid = '1;
      cyc();
      if (active_src != 0 && (seq.size() == 0 || seq[$] != int'(active_src)))
        seq.push_back(int'(active_src));
    end
    chk("scan_seq_len", 32'(seq.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < seq.size(); k++)
      chk($sformatf("scan_seq[%0d]", k), 32'(seq[k]), 32'(exp_seq[k]));
    scan_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
